// File: rtl/alu_unit.sv
// 16-bit registered ALU: ten opcodes, one cycle of latency, async active-low reset.
// Optional registered zero flag is enabled with the ALU_ZERO_FLAG_EN macro.
module alu_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  aluop,
   input  logic [15:0] aluin1,
   input  logic [15:0] aluin2,
   output logic [15:0] aluout,
   output logic        err
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic        zero
`endif
);

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_RED    = 4'h3,
      OP_SLL    = 4'h4,
      OP_SRA    = 4'h5,
      OP_ROR    = 4'h6,
      OP_PADDSB = 4'h7,
      OP_LLB    = 4'h8,
      OP_LHB    = 4'h9
   } alu_op_e;

   logic [15:0] aluout_d, aluout_q;
   logic        err_d, err_q;
   logic [3:0]  shamt;
   logic [9:0]  red_sum;
   logic [8:0]  lane_hi, lane_lo;

   // Returns {saturated, result} for a signed byte add clamped to [0x80, 0x7F].
   function automatic logic [8:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {a[7], a} + {b[7], b};
      if (s[8] != s[7])
         return {1'b1, (s[8] ? 8'h80 : 8'h7f)};
      return {1'b0, s[7:0]};
   endfunction

   always_comb begin
      aluout_d = '0;
      err_d    = 1'b0;
      shamt    = aluin2[3:0];
      red_sum  = {2'b00, aluin1[15:8]} + {2'b00, aluin2[15:8]}
               + {2'b00, aluin1[7:0]}  + {2'b00, aluin2[7:0]};
      lane_hi  = sat_add8(aluin1[15:8], aluin2[15:8]);
      lane_lo  = sat_add8(aluin1[7:0], aluin2[7:0]);
      case (alu_op_e'(aluop))
         OP_ADD:    {err_d, aluout_d} = {1'b0, aluin1} + {1'b0, aluin2};
         // Bit 16 of the widened difference is the unsigned borrow.
         OP_SUB:    {err_d, aluout_d} = {1'b0, aluin1} - {1'b0, aluin2};
         OP_XOR:    aluout_d = aluin1 ^ aluin2;
         OP_RED:    aluout_d = {6'b0, red_sum};
         OP_SLL:    aluout_d = aluin1 << shamt;
         OP_SRA:    aluout_d = $signed(aluin1) >>> shamt;
         // A shift by 16 in a 16-bit context yields 0, so amount 0 returns A.
         OP_ROR:    aluout_d = (aluin1 >> shamt) | (aluin1 << (5'd16 - {1'b0, shamt}));
         OP_PADDSB: begin
            aluout_d = {lane_hi[7:0], lane_lo[7:0]};
            err_d    = lane_hi[8] | lane_lo[8];
         end
         OP_LLB:    aluout_d = {aluin1[15:8], aluin2[7:0]};
         OP_LHB:    aluout_d = {aluin2[7:0], aluin1[7:0]};
         default: begin
            aluout_d = '0;
            err_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluout_q <= '0;
         err_q    <= 1'b0;
      end else begin
         aluout_q <= aluout_d;
         err_q    <= err_d;
      end
   end

   assign aluout = aluout_q;
   assign err    = err_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_d, zero_q;

   always_comb begin
      zero_d = (aluout_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) zero_q <= 1'b1;
      else        zero_q <= zero_d;
   end

   assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expected results.
module tb_alu_unit;

   logic        clk;
   logic        rst_n;
   logic [3:0]  aluop;
   logic [15:0] aluin1;
   logic [15:0] aluin2;
   logic [15:0] aluout;
   logic        err;
`ifdef ALU_ZERO_FLAG_EN
   logic        zero;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [15:0] prev_out;
   logic        prev_err;

   alu_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .aluop  (aluop),
      .aluin1 (aluin1),
      .aluin2 (aluin2),
      .aluout (aluout),
      .err    (err)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .zero   (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [15:0] exp_out, input logic exp_err);
      check({tag, ".out"}, aluout, exp_out);
      check({tag, ".err"}, {15'b0, err}, {15'b0, exp_err});
`ifdef ALU_ZERO_FLAG_EN
      check({tag, ".zero"}, {15'b0, zero}, {15'b0, (exp_out == 16'h0000)});
`endif
   endtask

   // Drive on the falling edge, confirm the previous result still holds, then
   // check the new result just after the next rising edge.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_out, input logic exp_err);
      @(negedge clk);
      aluop  = op;
      aluin1 = a;
      aluin2 = b;
      #1;
      check_outs({tag, ".hold"}, prev_out, prev_err);
      @(posedge clk);
      #1;
      check_outs(tag, exp_out, exp_err);
      prev_out = exp_out;
      prev_err = exp_err;
   endtask

   initial begin
      rst_n  = 1'b0;
      aluop  = 4'h0;
      aluin1 = 16'h0000;
      aluin2 = 16'h0000;
      #12;
      check_outs("reset", 16'h0000, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      prev_out = 16'h0000;
      prev_err = 1'b0;

      run_op("add",     4'h0, 16'hde15, 16'h3f3d, 16'h1d52, 1'b1);
      run_op("sub",     4'h1, 16'hde15, 16'h3f3d, 16'h9ed8, 1'b0);
      run_op("xor",     4'h2, 16'hde15, 16'h3f3d, 16'he128, 1'b0);
      run_op("sub_brw", 4'h1, 16'h0001, 16'h0002, 16'hffff, 1'b1);
      run_op("red",     4'h3, 16'h1122, 16'h9977, 16'h0143, 1'b0);
      run_op("red_max", 4'h3, 16'hffff, 16'hffff, 16'h03fc, 1'b0);
      run_op("sll",     4'h4, 16'h0001, 16'h0001, 16'h0002, 1'b0);
      run_op("sra",     4'h5, 16'h0004, 16'h0001, 16'h0002, 1'b0);
      run_op("sra_sgn", 4'h5, 16'h8000, 16'h000f, 16'hffff, 1'b0);
      run_op("ror",     4'h6, 16'h2222, 16'h0005, 16'h1111, 1'b0);
      run_op("ror0",    4'h6, 16'h1234, 16'h0000, 16'h1234, 1'b0);
      run_op("sll_hib", 4'h4, 16'h0001, 16'h0011, 16'h0002, 1'b0);
      run_op("padd",    4'h7, 16'h1234, 16'h1234, 16'h2468, 1'b0);
      run_op("padd_sat",4'h7, 16'h7f80, 16'h7f80, 16'h7f80, 1'b1);
      run_op("llb",     4'h8, 16'h1111, 16'h8888, 16'h1188, 1'b0);
      run_op("lhb",     4'h9, 16'h1111, 16'h8888, 16'h8811, 1'b0);
      run_op("ill_f",   4'hf, 16'h1111, 16'h8888, 16'h0000, 1'b1);
      run_op("ill_a",   4'ha, 16'hffff, 16'hffff, 16'h0000, 1'b1);
      run_op("xor_zero",4'h2, 16'h5a5a, 16'h5a5a, 16'h0000, 1'b0);
      run_op("add_nz",  4'h0, 16'h0100, 16'h0023, 16'h0123, 1'b0);

      // Asynchronous reset mid-cycle with nonzero outputs, then release.
      @(negedge clk);
      aluop  = 4'h0;
      aluin1 = 16'h0001;
      aluin2 = 16'h0001;
      rst_n  = 1'b0;
      #1;
      check_outs("rst_async", 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check_outs("rst_held", 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outs("rst_rel", 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check_outs("rst_first", 16'h0002, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
